// File: rtl/qcontrol_pkg.sv
// rtl/qcontrol_pkg.sv - shared state type and Q-format constants for the Q-control feedback path
package qcontrol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } qc_state_e;

  localparam int QC_GAIN_Q   = 22;
  localparam int QC_GAIN_ONE = 1 << QC_GAIN_Q;
  localparam int QC_QS_WIDTH = 16;

  // Largest value representable in a signed word of the given width.
  function automatic longint qc_sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed word of the given width.
  function automatic longint qc_sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  localparam longint QC_SAT_MAX = qc_sat_max(QC_QS_WIDTH);
  localparam longint QC_SAT_MIN = qc_sat_min(QC_QS_WIDTH);

endpackage

// File: rtl/qc_delay_ram.sv
// rtl/qc_delay_ram.sv - simple dual-port delay-line RAM, registered read, write-first on collision
module qc_delay_ram #(
  parameter int AW = 13,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_data_q;

  // Write port and registered read port; a same-address write is forwarded so delay 0 sees the new sample
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (re) begin
      rd_data_q <= (we && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/qcontrol_delay_gain.sv
// rtl/qcontrol_delay_gain.sv - delayed, Q22-scaled cantilever feedback; output clamp enabled by QC_SATURATE_EN
module qcontrol_delay_gain
  import qcontrol_pkg::*;
#(
  parameter int SIGNAL_WIDTH    = 16,
  parameter int SIGNAL_QS_WIDTH = QC_QS_WIDTH,
  parameter int GAIN_WIDTH      = 32,
  parameter int GAIN_Q          = QC_GAIN_Q,
  parameter int DELAY_AW        = 13
) (
  input  logic                              a_clk,
  input  logic                              a_rst,
  input  logic signed [SIGNAL_WIDTH-1:0]    S_AXIS_SIGNAL_tdata,
  input  logic                              S_AXIS_SIGNAL_tvalid,
  input  logic                              qc_enable,
  input  logic signed [GAIN_WIDTH-1:0]      qc_gain,
  input  logic        [DELAY_AW-1:0]        qc_delay,
  output logic signed [SIGNAL_QS_WIDTH-1:0] M_AXIS_QS_tdata,
  output logic                              M_AXIS_QS_tvalid,
  output logic                              qc_sat
);

  localparam int PW = SIGNAL_WIDTH + GAIN_WIDTH;
  localparam int QS = SIGNAL_QS_WIDTH;

  qc_state_e state_q, state_d;
  logic [DELAY_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DELAY_AW-1:0] fill_cnt_q, fill_cnt_d;
  logic [DELAY_AW-1:0] delay_q, delay_d;
  logic [DELAY_AW-1:0] rd_addr;
  logic                delay_changed;
  logic                wr_en;
  logic                live_s1;

  logic signed [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic [SIGNAL_WIDTH-1:0]      rd_data;
  logic                         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                         live1_q, live1_d, live2_q, live2_d;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic signed [PW-1:0]         shifted;
  logic signed [QS-1:0]         res;
  logic signed [QS-1:0]         out_q, out_d;
  logic                         out_live;

  // Reading wr_ptr - delay with write-first forwarding gives delay 0 the sample being written
  assign rd_addr = wr_ptr_q - delay_q;

  qc_delay_ram #(
    .AW (DELAY_AW),
    .DW (SIGNAL_WIDTH)
  ) u_delay_ram (
    .clk     (a_clk),
    .we      (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (S_AXIS_SIGNAL_tdata),
    .re      (S_AXIS_SIGNAL_tvalid),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // FSM next state, fill counting, write pointer and per-sample live decision
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    delay_d       = qc_delay;
    delay_changed = (qc_delay != delay_q);
    live_s1       = 1'b0;
    wr_en         = S_AXIS_SIGNAL_tvalid && qc_enable && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (qc_enable) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      end
      FILL: begin
        if (delay_changed) begin
          fill_cnt_d = '0;
        end else if (fill_cnt_q == delay_q) begin
          // buffer holds delay_q fresh samples: this sample already reads valid history
          state_d = RUN;
          live_s1 = S_AXIS_SIGNAL_tvalid;
        end else if (S_AXIS_SIGNAL_tvalid) begin
          fill_cnt_d = fill_cnt_q + DELAY_AW'(1);
        end
      end
      RUN: begin
        live_s1 = S_AXIS_SIGNAL_tvalid;
        if (delay_changed) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + DELAY_AW'(1);
    end

    // enable low wins over everything, including a simultaneous delay change
    if (!qc_enable) begin
      state_d    = IDLE;
      fill_cnt_d = '0;
      live_s1    = 1'b0;
    end
  end

  // Control registers
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      delay_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      delay_q    <= delay_d;
    end
  end

  // Pipeline: S1 gain capture, S2 full-width multiply, S3 output; valid bits shift every cycle
  always_comb begin
    gain_d  = gain_q;
    prod_d  = prod_q;
    v1_d    = S_AXIS_SIGNAL_tvalid;
    v2_d    = v1_q;
    v3_d    = v2_q;
    live1_d = live_s1;
    live2_d = v1_q && live1_q && qc_enable;
    if (S_AXIS_SIGNAL_tvalid) begin
      gain_d = qc_gain;
    end
    if (v1_q) begin
      prod_d = $signed({{GAIN_WIDTH{rd_data[SIGNAL_WIDTH-1]}}, rd_data}) *
               $signed({{SIGNAL_WIDTH{gain_q[GAIN_WIDTH-1]}}, gain_q});
    end
  end

  // Arithmetic shift floors toward -inf
  assign shifted  = prod_q >>> GAIN_Q;
  assign out_live = v2_q && live2_q && qc_enable;

`ifdef QC_SATURATE_EN
  localparam longint SAT_MAX = qc_sat_max(QS);
  localparam longint SAT_MIN = qc_sat_min(QS);

  logic clip;
  logic sat_q, sat_d;

  // Clamp into the output range and keep the sticky clip flag while active
  always_comb begin
    clip = 1'b0;
    res  = shifted[QS-1:0];
    if (longint'(shifted) > SAT_MAX) begin
      clip = 1'b1;
      res  = QS'(SAT_MAX);
    end else if (longint'(shifted) < SAT_MIN) begin
      clip = 1'b1;
      res  = QS'(SAT_MIN);
    end
    sat_d = sat_q;
    if (state_q == IDLE) begin
      sat_d = 1'b0;
    end else if (out_live && clip) begin
      sat_d = 1'b1;
    end
  end

  // Sticky saturation register
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign qc_sat = sat_q;
`else
  logic unused_shift_hi;

  // Two's-complement wrap: keep only the low output bits
  assign res             = shifted[QS-1:0];
  assign unused_shift_hi = ^shifted[PW-1:QS];
  assign qc_sat          = 1'b0;
`endif

  // Non-live samples (IDLE, FILL, disabled) still strobe out, but with zero data
  always_comb begin
    out_d = '0;
    if (out_live) begin
      out_d = res;
    end
  end

  // Pipeline registers
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      gain_q  <= '0;
      prod_q  <= '0;
      out_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      live1_q <= 1'b0;
      live2_q <= 1'b0;
    end else begin
      gain_q  <= gain_d;
      prod_q  <= prod_d;
      out_q   <= out_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      live1_q <= live1_d;
      live2_q <= live2_d;
    end
  end

  assign M_AXIS_QS_tdata  = out_q;
  assign M_AXIS_QS_tvalid = v3_q;

endmodule

// File: tb/tb_qcontrol_delay_gain.sv
// tb/tb_qcontrol_delay_gain.sv - scoreboard bench for qcontrol_delay_gain (QC_SATURATE_EN selects expectations)
module tb_qcontrol_delay_gain;
  import qcontrol_pkg::*;

  logic               a_clk;
  logic               a_rst;
  logic signed [15:0] s_tdata;
  logic               s_tvalid;
  logic               qc_enable;
  logic signed [31:0] qc_gain;
  logic [12:0]        qc_delay;
  logic signed [15:0] m_tdata;
  logic               m_tvalid;
  logic               qc_sat;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic signed [15:0] data;
    int                 due;
  } exp_t;

  exp_t sb_q[$];

  qcontrol_delay_gain dut (
    .a_clk                (a_clk),
    .a_rst                (a_rst),
    .S_AXIS_SIGNAL_tdata  (s_tdata),
    .S_AXIS_SIGNAL_tvalid (s_tvalid),
    .qc_enable            (qc_enable),
    .qc_gain              (qc_gain),
    .qc_delay             (qc_delay),
    .M_AXIS_QS_tdata      (m_tdata),
    .M_AXIS_QS_tvalid     (m_tvalid),
    .qc_sat               (qc_sat)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  always @(posedge a_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output strobe and checks data and latency
  always @(negedge a_clk) begin : monitor
    exp_t e;
    if (m_tvalid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL qs_unexpected: got strobe with data %0d, required no output", m_tdata);
      end else begin
        e = sb_q.pop_front();
        check("qs_data", longint'(m_tdata), longint'(e.data));
        check("qs_latency", longint'(cyc), longint'(e.due));
      end
    end
  end

  function automatic int xb(input int k);
    return int'(16'(k * 37 + 5));
  endfunction

  function automatic int sx(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  task automatic send(input int d, input int e);
    exp_t x;
    s_tdata  = 16'(d);
    s_tvalid = 1'b1;
    x.data   = 16'(e);
    x.due    = cyc + 3;
    sb_q.push_back(x);
    @(posedge a_clk);
    #1;
  endtask

  task automatic gap(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge a_clk);
    #1;
  endtask

  task automatic drain(input string name);
    gap(6);
    check({name, "_pending"}, longint'(sb_q.size()), 0);
  endtask

  task automatic restart(input int d, input int g);
    qc_enable = 1'b0;
    gap(2);
    qc_delay  = 13'(d);
    qc_gain   = g;
    qc_enable = 1'b1;
    gap(2);
  endtask

  int e_pos, e_neg, e_edge, e_sat;

  initial begin
`ifdef QC_SATURATE_EN
    e_pos  = 32767;
    e_neg  = -32768;
    e_edge = 32767;
    e_sat  = 1;
`else
    e_pos  = -25536;
    e_neg  = 25536;
    e_edge = -32768;
    e_sat  = 0;
`endif
    a_rst     = 1'b1;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    qc_enable = 1'b0;
    qc_gain   = '0;
    qc_delay  = '0;
    repeat (3) @(posedge a_clk);
    #1;
    check("rst_tvalid", longint'(m_tvalid), 0);
    check("rst_tdata", longint'(m_tdata), 0);
    check("rst_sat", longint'(qc_sat), 0);
    check("rst_state", longint'(dut.state_q), longint'(IDLE));
    a_rst = 1'b0;
    gap(1);

    // delay 0, unity gain, ramp back-to-back
    restart(0, QC_GAIN_ONE);
    for (int k = 0; k < 20; k++) send(k, k);
    drain("ramp_d0");

    // delay 5, impulse at sample 10
    restart(5, QC_GAIN_ONE);
    for (int k = 0; k < 20; k++) send((k == 10) ? 1000 : 0, (k == 15) ? 1000 : 0);
    drain("impulse_d5");

    // gain -0.5 floors; gain change applies to the very next sample
    restart(0, -(QC_GAIN_ONE / 2));
    send(101, -51);
    send(-101, 50);
    qc_gain = QC_GAIN_ONE;
    send(7, 7);
    qc_gain = 3 * QC_GAIN_ONE;
    send(-7, -21);
    drain("neg_gain");

    // gain 4: boundary, over-range, under-range
    restart(0, 4 * QC_GAIN_ONE);
    send(8191, 32764);
    drain("gain4_edge");
    check("sat_before_clip", longint'(qc_sat), 0);
    send(10000, e_pos);
    send(-10000, e_neg);
    send(8192, e_edge);
    send(0, 0);
    drain("gain4_clip");
    check("sat_sticky", longint'(qc_sat), longint'(e_sat));
    qc_enable = 1'b0;
    gap(2);
    check("sat_idle_clear", longint'(qc_sat), 0);

    // delay change 5 -> 8 in RUN, then drop enable mid-FILL
    restart(5, QC_GAIN_ONE);
    for (int k = 0; k < 10; k++) send(100 + k, (k < 5) ? 0 : 100 + k - 5);
    gap(1);
    qc_delay = 13'd8;
    gap(1);
    for (int k = 10; k < 22; k++) send(100 + k, (k - 10 < 8) ? 0 : 100 + k - 8);
    gap(1);
    qc_delay = 13'd12;
    gap(1);
    for (int k = 22; k < 25; k++) send(100 + k, 0);
    qc_enable = 1'b0;
    send(125, 0);
    check("disable_state", longint'(dut.state_q), longint'(IDLE));
    for (int k = 26; k < 29; k++) send(100 + k, 0);
    drain("delay_change");

    // maximum delay with pointer wrap
    restart(8191, QC_GAIN_ONE);
    for (int k = 0; k < 20000; k++) send(sx(xb(k)), (k < 8191) ? 0 : sx(xb(k - 8191)));
    drain("delay_max");

    // reset mid-stream drops everything in flight
    restart(0, QC_GAIN_ONE);
    for (int k = 1; k <= 6; k++) send(k * 11, k * 11);
    a_rst = 1'b1;
    #1;
    sb_q.delete();
    check("midrst_tvalid", longint'(m_tvalid), 0);
    check("midrst_tdata", longint'(m_tdata), 0);
    check("midrst_state", longint'(dut.state_q), longint'(IDLE));
    check("midrst_wrptr", longint'(dut.wr_ptr_q), 0);
    qc_enable = 1'b0;
    repeat (2) @(posedge a_clk);
    #1;
    check("midrst_tvalid_hold", longint'(m_tvalid), 0);
    a_rst = 1'b0;
    drain("post_reset");
    check("post_reset_state", longint'(dut.state_q), longint'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
